// File: rtl/test_port_driver.sv
// Test-port write initiator: begin symbol, Fibonacci terms ascending then
// descending (replayed from a LIFO), end symbol, each as a held addr/data/wen write.
module test_port_driver #(
    parameter int          N_TERMS   = 16,
    parameter int          HOLD      = 1,
    parameter int          GAP       = 1,
    parameter logic [29:0] TEST_PORT = 30'hFF,
    parameter logic [31:0] BEGIN_SYM = 32'h00000168,
    parameter logic [31:0] END_SYM   = 32'hFFFFFD5D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    localparam int SLOT  = HOLD + GAP;
    localparam int CW    = $clog2(SLOT);
    localparam int TW    = $clog2(N_TERMS + 1);
    localparam int DEPTH = 1 << TW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEGIN = 3'd1,
        S_ASC   = 3'd2,
        S_DESC  = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_term;
    logic [TW-1:0]   r_ptr;
    logic [31:0]     r_fa;
    logic [31:0]     r_fb;
    logic [29:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_wen;
    logic            r_busy;
    logic            r_done;
    logic [31:0]     r_lifo [DEPTH];

    logic [CW-1:0]   w_cnt_nxt;
    logic [TW-1:0]   w_term_nxt;
    logic [TW-1:0]   w_ptr_nxt;
    logic [TW-1:0]   w_top;
    logic [31:0]     w_fa_nxt;
    logic [31:0]     w_fb_nxt;
    logic [29:0]     w_addr_nxt;
    logic [31:0]     w_data_nxt;
    logic            w_wen_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_slot_end;
    logic            w_last_term;
    logic            w_load;
    logic            w_push;
    logic [31:0]     w_val;

    function automatic logic [31:0] byte_swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    assign w_slot_end  = (r_cnt == CW'(SLOT - 1));
    assign w_last_term = (r_term == TW'(N_TERMS));
    assign w_top       = r_ptr - TW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (!stall) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_BEGIN;
            S_BEGIN: if (w_slot_end) w_state_nxt = S_ASC;
            S_ASC:   if (w_slot_end && w_last_term) w_state_nxt = S_DESC;
            S_DESC:  if (w_slot_end && w_last_term) w_state_nxt = S_END;
            S_END:   if (w_slot_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new slot loads its value and raises wen; within a slot only the counter moves.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_term_nxt = r_term;
        w_ptr_nxt  = r_ptr;
        w_fa_nxt   = r_fa;
        w_fb_nxt   = r_fb;
        w_addr_nxt = r_addr;
        w_data_nxt = r_data;
        w_wen_nxt  = r_wen;
        w_busy_nxt = r_busy;
        w_done_nxt = r_done;
        w_load     = 1'b0;
        w_push     = 1'b0;
        w_val      = '0;
        if (r_state == S_IDLE) begin
            if (start) begin
                w_load     = 1'b1;
                w_val      = BEGIN_SYM;
                w_cnt_nxt  = '0;
                w_term_nxt = '0;
                w_ptr_nxt  = '0;
                w_fa_nxt   = 32'd0;
                w_fb_nxt   = 32'd1;
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b0;
            end
        end else if (!w_slot_end) begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_wen_nxt = (w_cnt_nxt < CW'(HOLD));
        end else begin
            w_cnt_nxt = '0;
            case (r_state)
                S_BEGIN: begin
                    w_load     = 1'b1;
                    w_push     = 1'b1;
                    w_val      = r_fa;
                    w_ptr_nxt  = r_ptr + TW'(1);
                    w_fa_nxt   = r_fb;
                    w_fb_nxt   = r_fa + r_fb;
                    w_term_nxt = TW'(1);
                end
                S_ASC: begin
                    w_load = 1'b1;
                    if (w_last_term) begin
                        w_val      = r_lifo[w_top];
                        w_ptr_nxt  = w_top;
                        w_term_nxt = TW'(1);
                    end else begin
                        w_push     = 1'b1;
                        w_val      = r_fa;
                        w_ptr_nxt  = r_ptr + TW'(1);
                        w_fa_nxt   = r_fb;
                        w_fb_nxt   = r_fa + r_fb;
                        w_term_nxt = r_term + TW'(1);
                    end
                end
                S_DESC: begin
                    w_load = 1'b1;
                    if (w_last_term) begin
                        w_val      = END_SYM;
                        w_term_nxt = '0;
                    end else begin
                        w_val      = r_lifo[w_top];
                        w_ptr_nxt  = w_top;
                        w_term_nxt = r_term + TW'(1);
                    end
                end
                default: begin
                    w_wen_nxt  = 1'b0;
                    w_addr_nxt = '0;
                    w_data_nxt = '0;
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_term_nxt = '0;
                    w_ptr_nxt  = '0;
                    w_fa_nxt   = 32'd0;
                    w_fb_nxt   = 32'd1;
                end
            endcase
        end
        if (w_load) begin
            w_wen_nxt  = 1'b1;
            w_addr_nxt = TEST_PORT;
            w_data_nxt = byte_swap(w_val);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_term <= '0;
            r_ptr  <= '0;
            r_fa   <= 32'd0;
            r_fb   <= 32'd1;
            r_addr <= '0;
            r_data <= '0;
            r_wen  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (!stall) begin
            r_cnt  <= w_cnt_nxt;
            r_term <= w_term_nxt;
            r_ptr  <= w_ptr_nxt;
            r_fa   <= w_fa_nxt;
            r_fb   <= w_fb_nxt;
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            r_wen  <= w_wen_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Storage only; the pointer alone decides what is valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!stall && w_push) begin
            r_lifo[r_ptr] <= r_fa;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        (!stall && w_push) |-> (r_ptr < TW'(N_TERMS)));
    assert property (@(posedge clk) disable iff (!rst)
        (!stall && r_state == S_END) |-> (r_ptr == '0));

    assign addr      = r_addr;
    assign data      = r_data;
    assign wen       = r_wen;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_test_port_driver.sv
// Directed bench for test_port_driver: three instances (defaults, HOLD=3/GAP=2,
// N_TERMS=50) share one clock and reset; a mux selects the one under test.
module tb_test_port_driver;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, start2;
    logic stall0, stall1, stall2;
    logic [29:0] addr0, addr1, addr2;
    logic [31:0] data0, data1, data2;
    logic wen0, wen1, wen2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] st0, st1, st2;

    always #5 clk = ~clk;

    test_port_driver u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .stall(stall0), .addr(addr0),
        .data(data0), .wen(wen0), .busy(busy0), .done(done0), .dbg_state(st0));

    test_port_driver #(.HOLD(3), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stall(stall1), .addr(addr1),
        .data(data1), .wen(wen1), .busy(busy1), .done(done1), .dbg_state(st1));

    test_port_driver #(.N_TERMS(50)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stall(stall2), .addr(addr2),
        .data(data2), .wen(wen2), .busy(busy2), .done(done2), .dbg_state(st2));

    int sel = 0;
    logic [29:0] m_addr;
    logic [31:0] m_data;
    logic m_wen, m_busy, m_done;
    logic [2:0] m_state;

    always_comb begin
        case (sel)
            1: begin m_addr = addr1; m_data = data1; m_wen = wen1; m_busy = busy1; m_done = done1; m_state = st1; end
            2: begin m_addr = addr2; m_data = data2; m_wen = wen2; m_busy = busy2; m_done = done2; m_state = st2; end
            default: begin m_addr = addr0; m_data = data0; m_wen = wen0; m_busy = busy0; m_done = done0; m_state = st0; end
        endcase
    end

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] vals_q[$];
    logic [29:0] addr_q[$];
    int hi_q[$];
    int lo_q[$];
    int run_len, done_k;
    logic done_v, first_busy, first_done, timed_out;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic drive(input logic s, input logic st);
        case (sel)
            1: begin start1 = s; stall1 = st; end
            2: begin start2 = s; stall2 = st; end
            default: begin start0 = s; stall0 = st; end
        endcase
    endtask

    // Expected logical values: begin, F0..F(n-1), F(n-1)..F0, end.
    task automatic build_exp(input int n);
        logic [31:0] a, b, t;
        logic [31:0] asc[$];
        exp_q.delete();
        exp_q.push_back(32'h00000168);
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < n; i++) begin
            asc.push_back(a);
            exp_q.push_back(a);
            t = a + b;
            a = b;
            b = t;
        end
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(asc[i]);
        exp_q.push_back(32'hFFFFFD5D);
    endtask

    // Pulses start, then records one run; k counts cycles after the start edge.
    task automatic capture(input int s1, input int s2, input int rk);
        logic pw, st, sv;
        int cur_hi, cur_lo;
        vals_q.delete(); addr_q.delete(); hi_q.delete(); lo_q.delete();
        run_len = 0; done_k = 0; done_v = 1'b0; timed_out = 1'b1;
        pw = 1'b0; cur_hi = 0; cur_lo = 0;
        @(negedge clk);
        drive(1'b1, 1'b0);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                first_busy = m_busy;
                first_done = m_done;
            end
            if (m_wen) begin
                if (cur_lo > 0) begin lo_q.push_back(cur_lo); cur_lo = 0; end
                if (!pw) begin vals_q.push_back(m_data); addr_q.push_back(m_addr); end
                cur_hi++;
            end else begin
                if (cur_hi > 0) begin hi_q.push_back(cur_hi); cur_hi = 0; end
                if (m_busy) cur_lo++;
            end
            if (m_busy) run_len++;
            if (!m_busy && !m_wen) begin
                if (cur_lo > 0) lo_q.push_back(cur_lo);
                done_k = k;
                done_v = m_done;
                timed_out = 1'b0;
                break;
            end
            pw = m_wen;
            st = (s1 > 0 && k >= s1 && k < s1 + 5) || (s2 > 0 && k >= s2 && k < s2 + 5);
            sv = (rk > 0 && k == rk);
            drive(sv, st);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start0 = 0; start1 = 0; start2 = 0; stall0 = 0; stall1 = 0; stall2 = 0;
        sel = 0;
        repeat (3) @(negedge clk);
        total++; if (m_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b expected 0", m_wen); end
        total++; if (m_addr !== 30'd0) begin bad++; $display("FAIL reset_addr: got %h expected 0", m_addr); end
        total++; if (m_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h expected 0", m_data); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", m_done); end
        total++; if (m_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", m_state); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        sel = 0;
        build_exp(16);
        capture(0, 0, 0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b expected 0", timed_out); end
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL basic_count: got %0d expected 34", vals_q.size()); end
        for (int i = 0; i < 34; i++) begin
            logic [31:0] got_d;
            logic [29:0] got_a;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            got_a = (i < addr_q.size()) ? addr_q[i] : 30'hx;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
            total++; if (got_a !== 30'hFF) begin bad++; $display("FAIL basic_addr[%0d]: got %h expected 0ff", i, got_a); end
        end
        total++; if (hi_q.size() !== 34 || lo_q.size() !== 34) begin bad++; $display("FAIL basic_pulses: got hi=%0d lo=%0d expected 34/34", hi_q.size(), lo_q.size()); end
        for (int i = 0; i < hi_q.size(); i++) begin
            total++; if (hi_q[i] !== 1) begin bad++; $display("FAIL basic_hi[%0d]: got %0d expected 1", i, hi_q[i]); end
        end
        for (int i = 0; i < lo_q.size(); i++) begin
            total++; if (lo_q[i] !== 1) begin bad++; $display("FAIL basic_lo[%0d]: got %0d expected 1", i, lo_q[i]); end
        end
        total++; if (first_busy !== 1'b1) begin bad++; $display("FAIL basic_first_busy: got %b expected 1", first_busy); end
        total++; if (run_len !== 68) begin bad++; $display("FAIL basic_run_len: got %0d expected 68", run_len); end
        total++; if (done_k !== 69) begin bad++; $display("FAIL basic_done_cycle: got %0d expected 69", done_k); end
        total++; if (done_v !== 1'b1) begin bad++; $display("FAIL basic_done: got %b expected 1", done_v); end
        @(negedge clk);
        total++; if (m_addr !== 30'd0) begin bad++; $display("FAIL basic_idle_addr: got %h expected 0", m_addr); end
        total++; if (m_state !== 3'd0) begin bad++; $display("FAIL basic_idle_state: got %0d expected 0", m_state); end
    endtask

    task automatic test_hold_gap();
        sel = 1;
        build_exp(16);
        capture(0, 0, 0);
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL hg_count: got %0d expected 34", vals_q.size()); end
        for (int i = 0; i < 34; i++) begin
            logic [31:0] got_d;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL hg_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
        end
        for (int i = 0; i < 34; i++) begin
            int gh, gl;
            gh = (i < hi_q.size()) ? hi_q[i] : -1;
            gl = (i < lo_q.size()) ? lo_q[i] : -1;
            total++; if (gh !== 3) begin bad++; $display("FAIL hg_hi[%0d]: got %0d expected 3", i, gh); end
            total++; if (gl !== 2) begin bad++; $display("FAIL hg_lo[%0d]: got %0d expected 2", i, gl); end
        end
        total++; if (run_len !== 170) begin bad++; $display("FAIL hg_run_len: got %0d expected 170", run_len); end
        total++; if (done_v !== 1'b1) begin bad++; $display("FAIL hg_done: got %b expected 1", done_v); end
    endtask

    task automatic test_stall();
        sel = 0;
        build_exp(16);
        // cycle 11 is the write of slot 5, cycle 17 its gap
        capture(11, 17, 0);
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL stall_count: got %0d expected 34", vals_q.size()); end
        for (int i = 0; i < 34; i++) begin
            logic [31:0] got_d;
            int gh, gl, eh;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            gh = (i < hi_q.size()) ? hi_q[i] : -1;
            gl = (i < lo_q.size()) ? lo_q[i] : -1;
            eh = (i == 5) ? 6 : 1;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
            total++; if (gh !== eh) begin bad++; $display("FAIL stall_hi[%0d]: got %0d expected %0d", i, gh, eh); end
            total++; if (gl !== eh) begin bad++; $display("FAIL stall_lo[%0d]: got %0d expected %0d", i, gl, eh); end
        end
        total++; if (run_len !== 78) begin bad++; $display("FAIL stall_run_len: got %0d expected 78", run_len); end
        total++; if (done_k !== 79) begin bad++; $display("FAIL stall_done_cycle: got %0d expected 79", done_k); end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        @(negedge clk);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        repeat (16) @(negedge clk);
        // cycle 17: write of F7 (13)
        total++; if (m_state !== 3'd2) begin bad++; $display("FAIL mid_state_asc: got %0d expected 2", m_state); end
        total++; if (m_data !== bswap(32'd13)) begin bad++; $display("FAIL mid_f7: got %h expected %h", m_data, bswap(32'd13)); end
        #2 rst = 1'b0;
        #1;
        total++; if (m_wen !== 1'b0) begin bad++; $display("FAIL mid_rst_wen: got %b expected 0", m_wen); end
        total++; if (m_addr !== 30'd0) begin bad++; $display("FAIL mid_rst_addr: got %h expected 0", m_addr); end
        total++; if (m_data !== 32'd0) begin bad++; $display("FAIL mid_rst_data: got %h expected 0", m_data); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b expected 0", m_busy); end
        total++; if (m_state !== 3'd0) begin bad++; $display("FAIL mid_rst_state: got %0d expected 0", m_state); end
        @(negedge clk);
        rst = 1'b1;
        build_exp(16);
        capture(0, 0, 0);
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL mid_count: got %0d expected 34", vals_q.size()); end
        for (int i = 0; i < 34; i++) begin
            logic [31:0] got_d;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL mid_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
        end
        total++; if (run_len !== 68) begin bad++; $display("FAIL mid_run_len: got %0d expected 68", run_len); end
    endtask

    task automatic test_wrap();
        sel = 2;
        build_exp(50);
        capture(0, 0, 0);
        total++; if (vals_q.size() !== 102) begin bad++; $display("FAIL wrap_count: got %0d expected 102", vals_q.size()); end
        for (int i = 0; i < 102; i++) begin
            logic [31:0] got_d;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
        end
        if (vals_q.size() == 102) begin
            total++; if (vals_q[48] !== bswap(32'hB11924E1)) begin bad++; $display("FAIL wrap_f47: got %h expected %h", vals_q[48], bswap(32'hB11924E1)); end
            total++; if (vals_q[49] !== bswap(32'h1E8D0A40)) begin bad++; $display("FAIL wrap_f48: got %h expected %h", vals_q[49], bswap(32'h1E8D0A40)); end
            total++; if (vals_q[50] !== bswap(32'hCFA62F21)) begin bad++; $display("FAIL wrap_f49: got %h expected %h", vals_q[50], bswap(32'hCFA62F21)); end
            total++; if (vals_q[52] !== bswap(32'h1E8D0A40)) begin bad++; $display("FAIL wrap_desc_f48: got %h expected %h", vals_q[52], bswap(32'h1E8D0A40)); end
        end
        total++; if (run_len !== 204) begin bad++; $display("FAIL wrap_run_len: got %0d expected 204", run_len); end
    endtask

    task automatic test_restart();
        sel = 0;
        build_exp(16);
        capture(0, 0, 20);
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL rs1_count: got %0d expected 34", vals_q.size()); end
        total++; if (run_len !== 68) begin bad++; $display("FAIL rs1_run_len: got %0d expected 68", run_len); end
        total++; if (done_v !== 1'b1) begin bad++; $display("FAIL rs1_done: got %b expected 1", done_v); end
        repeat (3) @(negedge clk);
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL rs_done_sticky: got %b expected 1", m_done); end
        capture(0, 0, 0);
        total++; if (first_done !== 1'b0) begin bad++; $display("FAIL rs2_done_clear: got %b expected 0", first_done); end
        total++; if (first_busy !== 1'b1) begin bad++; $display("FAIL rs2_busy: got %b expected 1", first_busy); end
        total++; if (vals_q.size() !== 34) begin bad++; $display("FAIL rs2_count: got %0d expected 34", vals_q.size()); end
        for (int i = 0; i < 34; i++) begin
            logic [31:0] got_d;
            got_d = (i < vals_q.size()) ? vals_q[i] : 32'hxxxxxxxx;
            total++; if (got_d !== bswap(exp_q[i])) begin bad++; $display("FAIL rs2_data[%0d]: got %h expected %h", i, got_d, bswap(exp_q[i])); end
        end
        total++; if (run_len !== 68) begin bad++; $display("FAIL rs2_run_len: got %0d expected 68", run_len); end
        total++; if (done_v !== 1'b1) begin bad++; $display("FAIL rs2_done: got %b expected 1", done_v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_gap();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
